note_period_sequencer: RTL and testbench
========================================

Name: note_period_sequencer

Overview:
- Upstream feeder for the divided-clock tone generator: drives a 24-bit half-rate `period` word plus a `mute` gate.
- Steps through a small programmable note table. Each entry is a period value and a duration in ticks.
- Inserts a silent gap between notes and optionally loops. Start/stop control comes from the board-level control logic.

Parameters:
- NUM_NOTES, 8, number of table entries (power of two, >= 2).
- TICK_CYCLES, 500000, CLOCK_50 cycles per duration tick (10 ms at 50 MHz).
- GAP_TICKS, 2, silent ticks between consecutive notes (0 = no gap).

Ports:
- CLOCK_50  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin playback from entry 0.
- stop  input  1  single-cycle request to abort playback.
- loop  input  1  at end of table, restart at entry 0 instead of finishing.
- note_wr_en  input  1  table write strobe.
- note_wr_addr  input  $clog2(NUM_NOTES)  table write index.
- note_wr_period  input  24  period value to store.
- note_wr_dur  input  8  duration in ticks to store; 0 marks end-of-sequence.
- period  output  24  period word to the clock divider.
- mute  output  1  1 = downstream output silenced.
- busy  output  1  1 while in LOAD/PLAY/GAP.
- note_idx  output  $clog2(NUM_NOTES)  index of the entry currently loaded.
- done  output  1  one-cycle pulse on natural sequence completion.

Behaviour:
- Reset (reset=0, takes effect immediately, no clock needed):
  - state IDLE; period=0, mute=1, busy=0, note_idx=0, done=0.
  - all table entries cleared to period=0, dur=0.
- Table writes: accepted in any state on a clock edge with note_wr_en=1.
  - A write to the entry currently playing has no effect until that entry is next LOADed.
- IDLE: period=0, mute=1.
  - start=1 and stop=0 -> note_idx<=0, go to LOAD.
- LOAD (exactly 1 cycle): examine entry[note_idx].
  - dur==0 -> end handling.
  - Otherwise: period<=entry.period, mute<=0, dur_cnt<=entry.dur, tick_cnt<=0, go to PLAY.
  - First PLAY cycle therefore shows the new period.
- PLAY:
  - tick_cnt counts 0..TICK_CYCLES-1 and wraps; each wrap decrements dur_cnt.
  - On the wrap where dur_cnt==1:
    - GAP_TICKS>0 -> mute<=1, gap_cnt<=GAP_TICKS, tick_cnt<=0, go to GAP.
    - GAP_TICKS==0 -> advance.
  - A note of dur N lasts exactly N*TICK_CYCLES cycles.
- GAP:
  - period holds its last value (no divider glitch); mute=1.
  - Counts gap_cnt ticks the same way, then advance.
- Advance:
  - note_idx==NUM_NOTES-1 -> end handling.
  - Otherwise note_idx<=note_idx+1, go to LOAD.
- End handling:
  - loop=1 and note_idx!=0 -> note_idx<=0, LOAD.
  - Otherwise go to DONE; mute<=1.
  - The note_idx!=0 guard prevents spinning on an empty table (entry 0 dur==0).
- DONE (1 cycle): done=1, period<=0, busy=0, go to IDLE.
- stop=1 in any non-IDLE state:
  - next cycle: IDLE, mute=1, period=0, busy=0, note_idx=0.
  - done is not pulsed.
- start while busy is ignored. start and stop in the same cycle: stop wins.
- Arithmetic:
  - tick_cnt is $clog2(TICK_CYCLES) bits wide.
  - dur_cnt is 8 bits; gap_cnt is wide enough for GAP_TICKS.
  - No counter ever wraps past its terminal value.

Test Plan (TICK_CYCLES=4, GAP_TICKS=1, NUM_NOTES=4):
1. Reset at power-up, then hold reset=1 with no start -> period=0, mute=1, busy=0, done=0, note_idx=0 indefinitely.
2. Program {382,2},{191,1},{0,0}; pulse start at edge 0, loop=0.
   - Cycle 1 LOAD.
   - Cycles 2-9: period=382, mute=0.
   - Cycles 10-13: mute=1, period=382.
   - Cycle 14 LOAD; cycles 15-18: period=191.
   - Cycles 19-22: gap.
   - Cycle 23 LOAD idx2; cycle 24: done=1; cycle 25: IDLE with period=0.
3. Program all four entries with dur=1 and loop=1 -> after idx3's gap, note_idx returns to 0 and playback repeats with done never asserted.
   - Pulse stop mid-PLAY -> next cycle busy=0, mute=1, period=0.
4. Clear the table (entry 0 dur=0), set loop=1, pulse start -> LOAD, DONE pulse, IDLE within 3 cycles, with no livelock.
5. Drop reset asynchronously halfway between clock edges during PLAY -> period=0, mute=1, busy=0 before the next CLOCK_50 edge.
   - After release, start replays from entry 0.
6. Pulse start and stop together from IDLE -> stays IDLE.
   - During PLAY of idx1, rewrite entry1 period to 100 -> the current note keeps its old period; the next loop pass plays period=100.

Source files
------------

// File: rtl/note_period_sequencer.sv
// note_period_sequencer
//   Walks a small programmable note table and feeds a half-rate period word
//   plus a mute gate to the divided-clock tone generator. Each entry holds a
//   period and a duration in ticks; a silent gap of GAP_TICKS ticks separates
//   notes, and playback can optionally loop back to entry 0.
//
// Ports
//   CLOCK_50        system clock
//   reset           asynchronous active-low reset (also clears the table)
//   start           1-cycle request to play from entry 0 (honoured in IDLE only)
//   stop            1-cycle abort; returns to IDLE without pulsing done
//   loop            at end of table restart at entry 0 instead of finishing
//   note_wr_en      table write strobe (accepted in any state)
//   note_wr_addr    table write index
//   note_wr_period  period value to store
//   note_wr_dur     duration in ticks to store; 0 marks end-of-sequence
//   period          period word to the clock divider
//   mute            1 = downstream output silenced
//   busy            1 while loading, playing or in a gap
//   note_idx        index of the entry currently loaded
//   done            1-cycle pulse on natural completion
module note_period_sequencer #(
  parameter int unsigned NUM_NOTES   = 8,
  parameter int unsigned TICK_CYCLES = 500000,
  parameter int unsigned GAP_TICKS   = 2
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         loop,
  input  logic                         note_wr_en,
  input  logic [$clog2(NUM_NOTES)-1:0] note_wr_addr,
  input  logic [23:0]                  note_wr_period,
  input  logic [7:0]                   note_wr_dur,
  output logic [23:0]                  period,
  output logic                         mute,
  output logic                         busy,
  output logic [$clog2(NUM_NOTES)-1:0] note_idx,
  output logic                         done
);

  localparam int unsigned IW = $clog2(NUM_NOTES);
  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [GW-1:0] GAP_INIT  = GW'(GAP_TICKS);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_NOTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [23:0]     period_q, period_d;
  logic            mute_q, mute_d;
  logic [IW-1:0]   note_idx_q, note_idx_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [7:0]      dur_cnt_q, dur_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;

  logic [23:0]     period_mem_q [NUM_NOTES];
  logic [7:0]      dur_mem_q    [NUM_NOTES];

  logic [23:0]     entry_period;
  logic [7:0]      entry_dur;
  logic            tick_wrap;
  logic            adv;
  logic            fin;

  // Note table. Entries are only sampled in LOAD, so rewriting the entry that
  // is currently sounding takes effect the next time it is loaded.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_NOTES; i++) begin
        period_mem_q[i] <= '0;
        dur_mem_q[i]    <= '0;
      end
    end else if (note_wr_en) begin
      period_mem_q[note_wr_addr] <= note_wr_period;
      dur_mem_q[note_wr_addr]    <= note_wr_dur;
    end
  end

  assign entry_period = period_mem_q[note_idx_q];
  assign entry_dur    = dur_mem_q[note_idx_q];

  // State register
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      period_q   <= '0;
      mute_q     <= 1'b1;
      note_idx_q <= '0;
      tick_cnt_q <= '0;
      dur_cnt_q  <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      mute_q     <= mute_d;
      note_idx_q <= note_idx_d;
      tick_cnt_q <= tick_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  // Next-state logic. Advance and end-of-sequence handling are shared by
  // several states, so they are raised as flags and resolved after the case;
  // stop is applied last so it overrides everything else.
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    mute_d     = mute_q;
    note_idx_d = note_idx_q;
    tick_cnt_d = tick_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    adv        = 1'b0;
    fin        = 1'b0;
    tick_wrap  = (tick_cnt_q == TICK_LAST);

    case (state_q)
      S_IDLE: begin
        period_d = '0;
        mute_d   = 1'b1;
        if (start && !stop) begin
          note_idx_d = '0;
          state_d    = S_LOAD;
        end
      end

      S_LOAD: begin
        if (entry_dur == 8'd0) begin
          fin = 1'b1;
        end else begin
          period_d   = entry_period;
          mute_d     = 1'b0;
          dur_cnt_d  = entry_dur;
          tick_cnt_d = '0;
          state_d    = S_PLAY;
        end
      end

      S_PLAY: begin
        if (tick_wrap) begin
          tick_cnt_d = '0;
          dur_cnt_d  = dur_cnt_q - 8'd1;
          if (dur_cnt_q == 8'd1) begin
            if (GAP_TICKS > 0) begin
              mute_d    = 1'b1;
              gap_cnt_d = GAP_INIT;
              state_d   = S_GAP;
            end else begin
              adv = 1'b1;
            end
          end
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end

      // period is left untouched so the divider never sees a glitch.
      S_GAP: begin
        if (tick_wrap) begin
          tick_cnt_d = '0;
          gap_cnt_d  = gap_cnt_q - 1'b1;
          if (gap_cnt_q == GW'(1)) begin
            adv = 1'b1;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        period_d = '0;
        mute_d   = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (adv) begin
      if (note_idx_q == IDX_LAST) begin
        fin = 1'b1;
      end else begin
        note_idx_d = note_idx_q + 1'b1;
        state_d    = S_LOAD;
      end
    end

    // The idx!=0 guard stops an empty table (entry 0 dur==0) from spinning.
    if (fin) begin
      if (loop && (note_idx_q != '0)) begin
        note_idx_d = '0;
        state_d    = S_LOAD;
      end else begin
        mute_d  = 1'b1;
        state_d = S_DONE;
      end
    end

    if (stop && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      mute_d     = 1'b1;
      period_d   = '0;
      note_idx_d = '0;
    end
  end

  // Outputs
  always_comb begin
    period   = period_q;
    mute     = mute_q;
    note_idx = note_idx_q;
    busy     = (state_q == S_LOAD) || (state_q == S_PLAY) || (state_q == S_GAP);
    done     = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_note_period_sequencer.sv
module tb_note_period_sequencer;

  localparam int NN = 4;
  localparam int TC = 4;
  localparam int GT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [23:0] wr_period = '0;
  logic [7:0]  wr_dur = '0;
  logic [23:0] period;
  logic        mute;
  logic        busy;
  logic [1:0]  note_idx;
  logic        done;

  note_period_sequencer #(
    .NUM_NOTES  (NN),
    .TICK_CYCLES(TC),
    .GAP_TICKS  (GT)
  ) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .loop          (loop),
    .note_wr_en    (wr_en),
    .note_wr_addr  (wr_addr),
    .note_wr_period(wr_period),
    .note_wr_dur   (wr_dur),
    .period        (period),
    .mute          (mute),
    .busy          (busy),
    .note_idx      (note_idx),
    .done          (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  int s = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference model: each phase is tracked as a count of remaining clock
  // cycles (note = dur*TC cycles, gap = GT*TC cycles).
  localparam int K_IDLE = 0, K_LOAD = 1, K_NOTE = 2, K_GAP = 3, K_DONE = 4;
  int          m_kind;
  int          m_left;
  int          m_idx;
  logic [23:0] m_period;
  logic        m_mute;
  logic [23:0] m_tp [NN];
  int          m_td [NN];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_kind = K_IDLE; m_left = 0; m_idx = 0; m_period = '0; m_mute = 1'b1;
      for (int i = 0; i < NN; i++) begin
        m_tp[i] = '0;
        m_td[i] = 0;
      end
    end else begin
      int k0;
      bit ending;
      bit nxt;
      k0 = m_kind; ending = 0; nxt = 0;
      case (m_kind)
        K_IDLE: if (start && !stop) begin m_idx = 0; m_kind = K_LOAD; end
        K_LOAD: begin
          if (m_td[m_idx] == 0) ending = 1;
          else begin
            m_period = m_tp[m_idx]; m_mute = 1'b0;
            m_left = m_td[m_idx] * TC; m_kind = K_NOTE;
          end
        end
        K_NOTE: begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            if (GT > 0) begin m_mute = 1'b1; m_left = GT * TC; m_kind = K_GAP; end
            else nxt = 1;
          end
        end
        K_GAP: begin
          m_left = m_left - 1;
          if (m_left == 0) nxt = 1;
        end
        default: begin m_period = '0; m_mute = 1'b1; m_kind = K_IDLE; end
      endcase
      if (nxt) begin
        if (m_idx == NN - 1) ending = 1;
        else begin m_idx = m_idx + 1; m_kind = K_LOAD; end
      end
      if (ending) begin
        if (loop && m_idx != 0) begin m_idx = 0; m_kind = K_LOAD; end
        else begin m_mute = 1'b1; m_kind = K_DONE; end
      end
      if (stop && k0 != K_IDLE) begin
        m_kind = K_IDLE; m_mute = 1'b1; m_period = '0; m_idx = 0;
      end
      if (wr_en) begin
        m_tp[wr_addr] = wr_period;
        m_td[wr_addr] = int'(wr_dur);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic e_busy, e_done;
    e_busy = (m_kind == K_LOAD) || (m_kind == K_NOTE) || (m_kind == K_GAP);
    e_done = (m_kind == K_DONE);
    checks++;
    if (period !== m_period || mute !== m_mute || busy !== e_busy ||
        note_idx !== 2'(m_idx) || done !== e_done) begin
      errors++;
      $display("FAIL outputs t=%0t got period=%0d mute=%b busy=%b idx=%0d done=%b required period=%0d mute=%b busy=%b idx=%0d done=%b",
               $time, period, mute, busy, note_idx, done, m_period, m_mute, e_busy, m_idx, e_done);
    end
  end

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic next_drive();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int a, input int p, input int d);
    wr_en = 1'b1; wr_addr = 2'(a); wr_period = 24'(p); wr_dur = 8'(d);
    next_drive();
    wr_en = 1'b0;
  endtask

  // Pulse start; edge 0 is the edge that samples it, cycle n follows edge n-1.
  task automatic go();
    start = 1'b1;
    @(posedge clk);
    #1 s = edge_cnt;
    #1 start = 1'b0;
  endtask

  task automatic at_cycle(input int n);
    while (edge_cnt < s + n - 1) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  task automatic drive_in(input int n);
    while (edge_cnt < s + n - 1) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    // Idle after reset
    repeat (5) @(posedge clk);
    @(negedge clk);
    pin("t1_period", period, 0);
    pin("t1_mute", mute, 1);
    pin("t1_busy", busy, 0);
    pin("t1_done", done, 0);
    pin("t1_idx", note_idx, 0);
    next_drive();

    // Two-note sequence, no loop
    wr(0, 382, 2); wr(1, 191, 1); wr(2, 0, 0);
    loop = 1'b0;
    go();
    at_cycle(1);  pin("t2_c1_busy", busy, 1); pin("t2_c1_idx", note_idx, 0);
    at_cycle(2);  pin("t2_c2_period", period, 382); pin("t2_c2_mute", mute, 0);
    at_cycle(9);  pin("t2_c9_mute", mute, 0);
    at_cycle(10); pin("t2_c10_mute", mute, 1); pin("t2_c10_period", period, 382);
    at_cycle(14); pin("t2_c14_idx", note_idx, 1);
    at_cycle(15); pin("t2_c15_period", period, 191); pin("t2_c15_mute", mute, 0);
    at_cycle(19); pin("t2_c19_mute", mute, 1);
    at_cycle(23); pin("t2_c23_idx", note_idx, 2); pin("t2_c23_busy", busy, 1);
    at_cycle(24); pin("t2_c24_done", done, 1); pin("t2_c24_busy", busy, 0);
    at_cycle(25); pin("t2_c25_period", period, 0); pin("t2_c25_done", done, 0);
    next_drive();

    // Looping over four one-tick notes, then stop mid-play
    wr(0, 10, 1); wr(1, 20, 1); wr(2, 30, 1); wr(3, 40, 1);
    loop = 1'b1;
    go();
    at_cycle(37); pin("t3_c37_idx", note_idx, 0); pin("t3_c37_busy", busy, 1);
    at_cycle(38); pin("t3_c38_period", period, 10);
    drive_in(48);
    pin("t3_c48_period", period, 20);
    stop = 1'b1;
    next_drive();
    stop = 1'b0;
    @(negedge clk);
    pin("t3_stop_busy", busy, 0); pin("t3_stop_mute", mute, 1);
    pin("t3_stop_period", period, 0); pin("t3_stop_done", done, 0);
    next_drive();

    // Empty table with loop set must terminate
    for (int i = 0; i < NN; i++) wr(i, 0, 0);
    loop = 1'b1;
    go();
    at_cycle(1); pin("t4_c1_busy", busy, 1);
    at_cycle(2); pin("t4_c2_done", done, 1);
    at_cycle(3); pin("t4_c3_busy", busy, 0); pin("t4_c3_done", done, 0);
    next_drive();

    // Asynchronous reset during play
    loop = 1'b0;
    wr(0, 500, 3);
    go();
    at_cycle(5); pin("t5_play_period", period, 500);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    pin("t5_rst_period", period, 0); pin("t5_rst_mute", mute, 1);
    pin("t5_rst_busy", busy, 0); pin("t5_rst_idx", note_idx, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    next_drive();
    wr(0, 700, 1);
    go();
    at_cycle(1);  pin("t5_replay_idx", note_idx, 0);
    at_cycle(2);  pin("t5_replay_period", period, 700);
    at_cycle(11); pin("t5_replay_done", done, 1);
    next_drive();

    // start+stop together from IDLE
    start = 1'b1; stop = 1'b1;
    next_drive();
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    pin("t6_ss_busy", busy, 0);
    next_drive();

    // Rewrite of the sounding entry is deferred to its next load
    wr(0, 10, 1); wr(1, 20, 1); wr(2, 30, 1); wr(3, 40, 1);
    loop = 1'b1;
    go();
    drive_in(12);
    wr(1, 100, 1);
    at_cycle(13); pin("t6_c13_period", period, 20);
    at_cycle(47); pin("t6_c47_period", period, 100);
    next_drive();
    stop = 1'b1;
    next_drive();
    stop = 1'b0;

    // Randomized traffic checked by the model every cycle
    loop = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      wr_en     = ($urandom_range(0, 9) == 0);
      wr_addr   = 2'($urandom);
      wr_period = 24'($urandom);
      wr_dur    = 8'($urandom_range(0, 3));
      start     = ($urandom_range(0, 19) == 0);
      stop      = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 199) == 0) loop = ~loop;
      next_drive();
    end
    wr_en = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (3) next_drive();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
